vga_fb_scan: RTL
================

Name: vga_fb_scan

Overview:
Parametrised VGA scan engine that generalises the existing fixed 640x480 VGA controller. It generates h/v timing for any resolution and sync polarity, and drives a linear framebuffer read address (row-major, pitch H_ACTIVE) without a multiplier. Sync, valid and pixel outputs are delay-matched to a framebuffer with configurable read latency. It sits between the picture memory and the board VGA pins in the SoC top.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)
RD_LAT, 0, framebuffer read latency in clocks, 0..4 (0 = combinational memory)
ADDR_W, 19, framebuffer address width
COLOR_W, 8, bits per colour channel

Ports:
clk  in  1  pixel clock
clrn  in  1  asynchronous active-low reset
en  in  1  scan enable; low freezes the counters
rd_en  out  1  framebuffer read strobe
rd_addr  out  ADDR_W  framebuffer pixel address
rd_data  in  3*COLOR_W  pixel {r,g,b}, valid RD_LAT clocks after rd_en
h_addr  out  10  current column (counter state, undelayed)
v_addr  out  10  current line (counter state, undelayed)
hsync  out  1  horizontal sync, delay-matched
vsync  out  1  vertical sync, delay-matched
valid  out  1  visible pixel on vga_r/g/b, delay-matched
vga_r  out  COLOR_W  red
vga_g  out  COLOR_W  green
vga_b  out  COLOR_W  blue
frame_start  out  1  one-clock pulse aligned with the first visible pixel of each frame

Behaviour:
- Totals: H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT likewise. Region order: active, FP, sync, BP. Counter value 0 = first visible pixel/line.
- h_cnt: 0..H_TOT-1. It increments on each clk with en=1 and wraps to 0. v_cnt increments when h_cnt wraps, and wraps to 0 after V_TOT-1.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hsync_raw is active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vsync_raw is active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
- Active level for both syncs = SYNC_POL.
- Read strobe: rd_en = active && en, combinational from the counter registers.
- Read address: rd_addr = v_cnt*H_ACTIVE + h_cnt whenever active. Implement it as a registered incrementing pointer:
  - +1 on each accepted active pixel;
  - cleared to 0 on the wrap from (H_TOT-1, V_TOT-1);
  - holds through blanking.
- h_addr = h_cnt and v_addr = v_cnt, undelayed. They are intended for a combinational picture source.
- Pipeline: {active&&en, hsync_raw, vsync_raw, first-pixel flag} passes through a D = RD_LAT+1 stage shift register, clocked every cycle regardless of en.
- Outputs are registered from the pipeline head:
  - valid = delayed active;
  - vga_r/g/b = rd_data fields when that stage's valid=1, else 0.
- Total latency: counter state at cycle t appears on the pins at t+RD_LAT+1.
- en=0:
  - counters and rd_addr hold; rd_en=0;
  - blank entries (valid=0, syncs inactive) shift into the pipeline;
  - on en=1 the scan resumes at the held position.
- frame_start is the delayed flag for (h_cnt,v_cnt)=(0,0) with en=1: exactly one clock per frame.
- Reset (clrn=0, any time, asynchronous):
  - counters=0, rd_addr=0, pipeline cleared;
  - hsync=vsync=~SYNC_POL, valid=0, rgb=0, frame_start=0, rd_en=0.
  - The first clock after release starts a frame with pixel (0,0).
- Width rules:
  - counters are 10 bits; H_TOT and V_TOT must be <= 1024;
  - H_ACTIVE*V_ACTIVE must be <= 2^ADDR_W;
  - RD_LAT outside 0..4 is an elaboration error.

Test Plan:
- Reset: hold clrn=0 with clocks running -> hsync=vsync=1, valid=0, rgb=0, rd_addr=0, rd_en=0 (SYNC_POL=0).
- Small timing: H=4/1/2/1, V=3/1/1/1, RD_LAT=0 -> H_TOT=8, and hsync low on h_cnt 5..6 (delayed 1 clock). vsync low on line 4. rd_addr runs 0..11 over the 12 visible clocks, then 0 again at frame 2. frame_start once per 48 clocks.
- Latency: same config with RD_LAT=2 and a model returning rd_data=rd_addr delayed 2 -> vga_b equals pixel index on each valid clock. valid goes high 3 clocks after the first rd_en.
- Pause: drop en for 5 clocks at pixel (2,1) -> valid low 5 clocks, then resumes. The next valid pixel carries address 6 with no skip or duplicate.
- Async reset mid-frame at pixel (3,2) -> outputs go to reset values immediately without a clock edge. After release, rd_addr=0 and frame_start pulses on schedule.
- SYNC_POL=1 -> syncs idle low and pulse high with identical timing.

Source files
------------

// File: rtl/vga_fb_scan.sv
// Parametrised VGA scan engine: h/v timing, linear framebuffer read pointer and
// sync/valid/pixel outputs delay-matched to the framebuffer read latency.
module vga_fb_scan #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int RD_LAT   = 0,
    parameter int ADDR_W   = 19,
    parameter int COLOR_W  = 8
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   en,
    output logic                   rd_en,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [3*COLOR_W-1:0]   rd_data,
    output logic [9:0]             h_addr,
    output logic [9:0]             v_addr,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   valid,
    output logic [COLOR_W-1:0]     vga_r,
    output logic [COLOR_W-1:0]     vga_g,
    output logic [COLOR_W-1:0]     vga_b,
    output logic                   frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int D     = RD_LAT + 1;

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST = 11'(H_TOT - 1);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SS   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SE   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST = 11'(V_TOT - 1);
    localparam logic        POL    = (SYNC_POL != 0);

    if (RD_LAT < 0 || RD_LAT > 4) begin : g_bad_lat
        $error("vga_fb_scan: RD_LAT must be within 0..4");
    end
    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_tot
        $error("vga_fb_scan: H_TOT and V_TOT must not exceed 1024");
    end
    if ((longint'(H_ACTIVE) * longint'(V_ACTIVE)) > (longint'(1) << ADDR_W)) begin : g_bad_addr
        $error("vga_fb_scan: H_ACTIVE*V_ACTIVE does not fit in ADDR_W");
    end

    logic [9:0]        h_cnt;
    logic [9:0]        v_cnt;
    logic [ADDR_W-1:0] ptr;
    logic              h_end;
    logic              v_end;
    logic              active;
    logic              acc;
    logic              hs_raw;
    logic              vs_raw;
    logic [3:0]        cur;           // {first pixel, vsync, hsync, valid}
    logic [3:0]        ctl_p [D];
    logic              vld_rd;
    logic [3*COLOR_W-1:0] rgb_p;

    assign h_end  = ({1'b0, h_cnt} == H_LAST);
    assign v_end  = ({1'b0, v_cnt} == V_LAST);
    assign active = ({1'b0, h_cnt} < H_ACT) && ({1'b0, v_cnt} < V_ACT);
    assign hs_raw = ({1'b0, h_cnt} >= H_SS) && ({1'b0, h_cnt} < H_SE);
    assign vs_raw = ({1'b0, v_cnt} >= V_SS) && ({1'b0, v_cnt} < V_SE);
    assign acc    = active && en;

    // Paused cycles enter the pipeline as blank entries.
    assign cur = {en && (h_cnt == 10'd0) && (v_cnt == 10'd0), en && vs_raw, en && hs_raw, acc};

    assign rd_en   = acc && clrn;
    assign rd_addr = ptr;
    assign h_addr  = h_cnt;
    assign v_addr  = v_cnt;

    // Stage 0: scan counters and the row-major read pointer
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            h_cnt <= '0;
            v_cnt <= '0;
            ptr   <= '0;
        end else if (en) begin
            if (h_end) begin
                h_cnt <= '0;
                v_cnt <= v_end ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
            if (h_end && v_end)
                ptr <= '0;
            else if (active)
                ptr <= ptr + ADDR_W'(1);
        end
    end

    // Valid flag of the entry whose read data is on rd_data this cycle.
    if (RD_LAT == 0) begin : g_lat0
        assign vld_rd = cur[0];
    end else begin : g_latn
        assign vld_rd = ctl_p[RD_LAT-1][0];
    end

    // Stages 1..D: control delay line; pixel data captured at the last stage
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < D; i++) ctl_p[i] <= '0;
            rgb_p <= '0;
        end else begin
            ctl_p[0] <= cur;
            for (int i = 1; i < D; i++) ctl_p[i] <= ctl_p[i-1];
            rgb_p <= vld_rd ? rd_data : '0;
        end
    end

    assign valid       = ctl_p[D-1][0];
    assign hsync       = ctl_p[D-1][1] ? POL : ~POL;
    assign vsync       = ctl_p[D-1][2] ? POL : ~POL;
    assign frame_start = ctl_p[D-1][3];
    assign vga_r       = rgb_p[3*COLOR_W-1:2*COLOR_W];
    assign vga_g       = rgb_p[2*COLOR_W-1:COLOR_W];
    assign vga_b       = rgb_p[COLOR_W-1:0];

endmodule
